// File: rtl/decode_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decode_queue_pkg
//  Purpose  : MIPS opcode/funct/rt fields, ALU control and branch-judge codes
//  Revision : 1.0
// ============================================================================
package decode_queue_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_SLTIU   = 6'b001011;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SB      = 6'b101000;
    localparam logic [5:0] OP_SW      = 6'b101011;

    localparam logic [5:0] FN_SLL     = 6'b000000;
    localparam logic [5:0] FN_SRL     = 6'b000010;
    localparam logic [5:0] FN_SRA     = 6'b000011;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [5:0] FN_ADD     = 6'b100000;
    localparam logic [5:0] FN_ADDU    = 6'b100001;
    localparam logic [5:0] FN_SUB     = 6'b100010;
    localparam logic [5:0] FN_SUBU    = 6'b100011;
    localparam logic [5:0] FN_AND     = 6'b100100;
    localparam logic [5:0] FN_OR      = 6'b100101;
    localparam logic [5:0] FN_XOR     = 6'b100110;
    localparam logic [5:0] FN_NOR     = 6'b100111;
    localparam logic [5:0] FN_SLT     = 6'b101010;
    localparam logic [5:0] FN_SLTU    = 6'b101011;

    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;
    localparam logic [4:0] RT_BLTZAL  = 5'b10000;
    localparam logic [4:0] RT_BGEZAL  = 5'b10001;

    // ALU_DONOTHING doubles as the "not a branch" branch-judge code
    localparam logic [5:0] ALU_DONOTHING = 6'd0;
    localparam logic [5:0] ALU_ADD       = 6'd1;
    localparam logic [5:0] ALU_ADDU      = 6'd2;
    localparam logic [5:0] ALU_SUB       = 6'd3;
    localparam logic [5:0] ALU_SUBU      = 6'd4;
    localparam logic [5:0] ALU_AND       = 6'd5;
    localparam logic [5:0] ALU_OR        = 6'd6;
    localparam logic [5:0] ALU_XOR       = 6'd7;
    localparam logic [5:0] ALU_NOR       = 6'd8;
    localparam logic [5:0] ALU_SLT       = 6'd9;
    localparam logic [5:0] ALU_SLTU      = 6'd10;
    localparam logic [5:0] ALU_SLL       = 6'd11;
    localparam logic [5:0] ALU_SRL       = 6'd12;
    localparam logic [5:0] ALU_SRA       = 6'd13;
    localparam logic [5:0] ALU_LUI       = 6'd14;

    localparam logic [4:0] ALU_EQ        = 5'd1;
    localparam logic [4:0] ALU_NEQ       = 5'd2;
    localparam logic [4:0] ALU_LEZ       = 5'd3;
    localparam logic [4:0] ALU_GTZ       = 5'd4;
    localparam logic [4:0] ALU_LTZ       = 5'd5;
    localparam logic [4:0] ALU_GEZ       = 5'd6;

    function automatic logic is_jump(input logic [5:0] op, input logic [5:0] funct);
        return (op == OP_J) || (op == OP_JAL) ||
               ((op == OP_SPECIAL) && ((funct == FN_JR) || (funct == FN_JALR)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : alu_decoder
//  Purpose  : Combinational MIPS decode to ALU control and branch-judge codes
//  Revision : 1.0
// ============================================================================
module alu_decoder
    import decode_queue_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [4:0] i_rt,
    input  logic [5:0] i_funct,
    output logic [5:0] o_alu_control,
    output logic [4:0] o_branch_judge
);

    always_comb begin
        o_alu_control  = ALU_DONOTHING;
        o_branch_judge = 5'(ALU_DONOTHING);
        case (i_opcode)
            OP_SPECIAL: begin
                case (i_funct)
                    FN_ADD:  o_alu_control = ALU_ADD;
                    FN_ADDU: o_alu_control = ALU_ADDU;
                    FN_SUB:  o_alu_control = ALU_SUB;
                    FN_SUBU: o_alu_control = ALU_SUBU;
                    FN_AND:  o_alu_control = ALU_AND;
                    FN_OR:   o_alu_control = ALU_OR;
                    FN_XOR:  o_alu_control = ALU_XOR;
                    FN_NOR:  o_alu_control = ALU_NOR;
                    FN_SLT:  o_alu_control = ALU_SLT;
                    FN_SLTU: o_alu_control = ALU_SLTU;
                    FN_SLL:  o_alu_control = ALU_SLL;
                    FN_SRL:  o_alu_control = ALU_SRL;
                    FN_SRA:  o_alu_control = ALU_SRA;
                    default: o_alu_control = ALU_DONOTHING;
                endcase
            end
            OP_REGIMM: begin
                case (i_rt)
                    RT_BLTZ, RT_BLTZAL: o_branch_judge = ALU_LTZ;
                    RT_BGEZ, RT_BGEZAL: o_branch_judge = ALU_GEZ;
                    default:            o_branch_judge = 5'(ALU_DONOTHING);
                endcase
            end
            OP_BEQ:   o_branch_judge = ALU_EQ;
            OP_BNE:   o_branch_judge = ALU_NEQ;
            OP_BLEZ:  o_branch_judge = ALU_LEZ;
            OP_BGTZ:  o_branch_judge = ALU_GTZ;
            OP_ADDI:  o_alu_control  = ALU_ADD;
            OP_ADDIU: o_alu_control  = ALU_ADDU;
            OP_SLTI:  o_alu_control  = ALU_SLT;
            OP_SLTIU: o_alu_control  = ALU_SLTU;
            OP_ANDI:  o_alu_control  = ALU_AND;
            OP_ORI:   o_alu_control  = ALU_OR;
            OP_XORI:  o_alu_control  = ALU_XOR;
            OP_LUI:   o_alu_control  = ALU_LUI;
            OP_LB, OP_LW, OP_SB, OP_SW: o_alu_control = ALU_ADDU;
            default:  o_alu_control  = ALU_DONOTHING;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
//  Module   : decode_queue
//  Purpose  : Decode-on-enqueue circular queue between fetch and issue
//  Revision : 1.0
// ============================================================================
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 8
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [FETCH_W-1:0]            in_valid,
    input  logic [32*FETCH_W-1:0]         in_instr,
    input  logic [32*FETCH_W-1:0]         in_pc,
    output logic                          in_ready,
    output logic [ISSUE_W-1:0]            out_valid,
    output logic [32*ISSUE_W-1:0]         out_instr,
    output logic [32*ISSUE_W-1:0]         out_pc,
    output logic [6*ISSUE_W-1:0]          out_alu_control,
    output logic [5*ISSUE_W-1:0]          out_branch_judge,
    input  logic [ISSUE_W-1:0]            out_take,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [31:0]      r_instr [DEPTH];
    logic [31:0]      r_pc    [DEPTH];
    logic [5:0]       r_alu   [DEPTH];
    logic [4:0]       r_bj    [DEPTH];

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic [5:0]       w_dec_alu [FETCH_W];
    logic [4:0]       w_dec_bj  [FETCH_W];
    logic [CNT_W-1:0] w_enq;
    logic [CNT_W-1:0] w_deq;

    assign count    = r_count;
    // Readiness looks only at the current occupancy, never at same-cycle takes
    assign in_ready = (r_count <= CNT_W'(DEPTH - FETCH_W));

    generate
        for (genvar g = 0; g < FETCH_W; g++) begin : g_dec
            alu_decoder u_alu_decoder (
                .i_opcode       (in_instr[32*g+26 +: 6]),
                .i_rt           (in_instr[32*g+16 +: 5]),
                .i_funct        (in_instr[32*g    +: 6]),
                .o_alu_control  (w_dec_alu[g]),
                .o_branch_judge (w_dec_bj[g])
            );
        end
    endgenerate

    always_comb begin
        w_enq = '0;
        w_deq = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            w_enq = w_enq + CNT_W'(in_valid[i]);
        end
        if (!in_ready) begin
            w_enq = '0;
        end
        for (int i = 0; i < ISSUE_W; i++) begin
            w_deq = w_deq + CNT_W'(out_take[i] & out_valid[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (in_ready && !flush) begin
            for (int i = 0; i < FETCH_W; i++) begin
                if (in_valid[i]) begin
                    r_instr[r_tail + PTR_W'(i)] <= in_instr[32*i +: 32];
                    r_pc[r_tail + PTR_W'(i)]    <= in_pc[32*i +: 32];
                    r_alu[r_tail + PTR_W'(i)]   <= w_dec_alu[i];
                    r_bj[r_tail + PTR_W'(i)]    <= w_dec_bj[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_deq);
            r_tail  <= r_tail + PTR_W'(w_enq);
            r_count <= r_count + w_enq - w_deq;
        end
    end

    generate
        for (genvar g = 0; g < ISSUE_W; g++) begin : g_rd
            logic [PTR_W-1:0] w_idx;
            assign w_idx = r_head + PTR_W'(g);
            assign out_instr[32*g +: 32]       = r_instr[w_idx];
            assign out_pc[32*g +: 32]          = r_pc[w_idx];
            assign out_alu_control[6*g +: 6]   = r_alu[w_idx];
            assign out_branch_judge[5*g +: 5]  = r_bj[w_idx];
        end
    endgenerate

    assign out_valid[0] = (r_count != '0);

    // A branch or jump second in line waits for lane 0 so its delay slot trails it
    generate
        if (ISSUE_W == 2) begin : g_lane_rule
            logic [PTR_W-1:0] w_idx1;
            logic             w_ctl1;
            assign w_idx1       = r_head + PTR_W'(1);
            assign w_ctl1       = (r_bj[w_idx1] != 5'(ALU_DONOTHING)) ||
                                  is_jump(r_instr[w_idx1][31:26], r_instr[w_idx1][5:0]);
            assign out_valid[1] = (r_count > CNT_W'(1)) && !w_ctl1;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`timescale 1ns/1ps
module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int FETCH_W = 2;
    localparam int ISSUE_W = 2;
    localparam int DEPTH   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [1:0]  in_valid = 2'b00;
    logic [63:0] in_instr = '0;
    logic [63:0] in_pc = '0;
    logic        in_ready;
    logic [1:0]  out_valid;
    logic [63:0] out_instr;
    logic [63:0] out_pc;
    logic [11:0] out_alu_control;
    logic [9:0]  out_branch_judge;
    logic [1:0]  out_take = 2'b00;
    logic [3:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    decode_queue #(.FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_alu_control(out_alu_control), .out_branch_judge(out_branch_judge),
        .out_take(out_take), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    ent_t mq[$];

    // returns {alu_control[5:0], branch_judge[4:0]}
    function automatic logic [10:0] ref_dec(input logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rt;
        logic [5:0] a;
        logic [4:0] b;
        op = ins[31:26]; fn = ins[5:0]; rt = ins[20:16];
        a = 6'd0; b = 5'd0;
        if (op == 6'h00) begin
            if      (fn == 6'h20) a = ALU_ADD;
            else if (fn == 6'h21) a = ALU_ADDU;
            else if (fn == 6'h22) a = ALU_SUB;
            else if (fn == 6'h23) a = ALU_SUBU;
            else if (fn == 6'h24) a = ALU_AND;
            else if (fn == 6'h25) a = ALU_OR;
            else if (fn == 6'h26) a = ALU_XOR;
            else if (fn == 6'h27) a = ALU_NOR;
            else if (fn == 6'h2a) a = ALU_SLT;
            else if (fn == 6'h2b) a = ALU_SLTU;
            else if (fn == 6'h00) a = ALU_SLL;
            else if (fn == 6'h02) a = ALU_SRL;
            else if (fn == 6'h03) a = ALU_SRA;
        end else if (op == 6'h01) begin
            if (rt == 5'h00 || rt == 5'h10) b = ALU_LTZ;
            if (rt == 5'h01 || rt == 5'h11) b = ALU_GEZ;
        end else if (op == 6'h04) b = ALU_EQ;
        else if (op == 6'h05) b = ALU_NEQ;
        else if (op == 6'h06) b = ALU_LEZ;
        else if (op == 6'h07) b = ALU_GTZ;
        else if (op == 6'h08) a = ALU_ADD;
        else if (op == 6'h09) a = ALU_ADDU;
        else if (op == 6'h0a) a = ALU_SLT;
        else if (op == 6'h0b) a = ALU_SLTU;
        else if (op == 6'h0c) a = ALU_AND;
        else if (op == 6'h0d) a = ALU_OR;
        else if (op == 6'h0e) a = ALU_XOR;
        else if (op == 6'h0f) a = ALU_LUI;
        else if (op == 6'h20 || op == 6'h23 || op == 6'h28 || op == 6'h2b) a = ALU_ADDU;
        return {a, b};
    endfunction

    function automatic bit ref_ctl(input logic [31:0] ins);
        logic [10:0] d;
        d = ref_dec(ins);
        return (d[4:0] != 5'd0) || (ins[31:26] == 6'h02) || (ins[31:26] == 6'h03) ||
               (ins[31:26] == 6'h00 && (ins[5:0] == 6'h08 || ins[5:0] == 6'h09));
    endfunction

    function automatic bit m_ready();
        return mq.size() <= DEPTH - FETCH_W;
    endfunction

    function automatic logic [1:0] m_valid();
        logic [1:0] v;
        v[0] = (mq.size() > 0);
        v[1] = (mq.size() > 1) && !ref_ctl(mq[1].instr);
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            mq.delete();
        end else begin
            automatic bit rdy = m_ready();
            for (int i = 0; i < ISSUE_W; i++)
                if (out_take[i] && mq.size() > 0) void'(mq.pop_front());
            if (rdy)
                for (int i = 0; i < FETCH_W; i++)
                    if (in_valid[i]) mq.push_back('{in_instr[32*i +: 32], in_pc[32*i +: 32]});
        end
    end

    always @(negedge clk) begin : cmp
        logic [1:0]  ev;
        logic [10:0] d;
        ev = m_valid();
        chk("count", 64'(count), 64'(mq.size()));
        chk("in_ready", 64'(in_ready), 64'(m_ready()));
        chk("out_valid", 64'(out_valid), 64'(ev));
        for (int i = 0; i < ISSUE_W; i++) begin
            if (ev[i]) begin
                d = ref_dec(mq[i].instr);
                chk("out_instr", 64'(out_instr[32*i +: 32]), 64'(mq[i].instr));
                chk("out_pc", 64'(out_pc[32*i +: 32]), 64'(mq[i].pc));
                chk("out_alu_control", 64'(out_alu_control[6*i +: 6]), 64'(d[10:5]));
                chk("out_branch_judge", 64'(out_branch_judge[5*i +: 5]), 64'(d[4:0]));
            end
        end
        chk("take_subset_of_valid", 64'(out_take & ~out_valid), 64'd0);
        chk("count_bound", 64'(count > 4'(DEPTH)), 64'd0);
    end

    // ---------------- stimulus ----------------
    logic [31:0] next_pc;

    function automatic logic [31:0] gen_instr(input int kind);
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); imm = 16'($urandom);
        case (kind)
            0:  return {6'h00, rs, rt, rd, 5'h00, 6'h21};
            1:  return {6'h00, rs, rt, rd, 5'h00, 6'h23};
            2:  return {6'h00, rs, rt, rd, 5'h00, 6'h25};
            3:  return {6'h00, 5'h00, rt, rd, imm[4:0], 6'h00};
            4:  return {6'h00, rs, 15'h0, 6'h08};
            5:  return {6'h00, rs, 5'h00, rd, 5'h00, 6'h09};
            6:  return {6'h09, rs, rt, imm};
            7:  return {6'h0f, 5'h00, rt, imm};
            8:  return {6'h23, rs, rt, imm};
            9:  return {6'h04, rs, rt, imm};
            10: return {6'h05, rs, rt, imm};
            11: return {6'h01, rs, 5'h01, imm};
            12: return {6'h01, rs, 5'h10, imm};
            13: return {6'h02, 26'($urandom)};
            14: return {6'h03, 26'($urandom)};
            15: return {6'h0a, rs, rt, imm};
            16: return {6'h06, rs, 5'h00, imm};
            default: return $urandom;
        endcase
    endfunction

    task automatic set_in(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1);
        in_valid = v;
        in_instr = {i1, i0};
        in_pc    = {next_pc + 32'd4, next_pc};
    endtask

    // Advance one clock; pcs move on only when the lanes are actually accepted
    task automatic cyc();
        automatic bit acc = m_ready() && !flush;
        automatic int n = $countones(in_valid);
        @(posedge clk);
        #1;
        if (acc) next_pc = next_pc + 32'(4 * n);
    endtask

    initial begin
        int k;
        int budget;
        logic [1:0] v;
        next_pc = 32'h100;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        // 1: addu + addiu
        set_in(2'b11, 32'h00851021, 32'h24020005);
        cyc();
        set_in(2'b00, 32'h0, 32'h0);
        chk("t1_out_valid", 64'(out_valid), 64'h3);
        chk("t1_alu0", 64'(out_alu_control[5:0]), 64'(ALU_ADDU));
        chk("t1_alu1", 64'(out_alu_control[11:6]), 64'(ALU_ADDU));
        chk("t1_pc0", 64'(out_pc[31:0]), 64'h100);
        chk("t1_pc1", 64'(out_pc[63:32]), 64'h104);
        chk("t1_count", 64'(count), 64'd2);

        // 2: nop then beq, while draining the previous pair
        set_in(2'b11, 32'h00000000, 32'h10850003);
        out_take = 2'b11;
        cyc();
        set_in(2'b00, 32'h0, 32'h0);
        out_take = 2'b00;
        chk("t2_lane1_masked", 64'(out_valid), 64'h1);
        chk("t2_nop_alu", 64'(out_alu_control[5:0]), 64'(ALU_SLL));
        out_take = 2'b01;
        cyc();
        chk("t2_beq_lane0", 64'(out_instr[31:0]), 64'h10850003);
        chk("t2_beq_judge", 64'(out_branch_judge[4:0]), 64'(ALU_EQ));
        chk("t2_beq_valid", 64'(out_valid), 64'h1);
        cyc();
        out_take = 2'b00;

        // 3: fill to DEPTH, extra input held and ignored, then take two
        for (int i = 0; i < 4; i++) begin
            set_in(2'b11, gen_instr(0), gen_instr(6));
            cyc();
        end
        chk("t3_full_count", 64'(count), 64'd8);
        chk("t3_full_ready", 64'(in_ready), 64'd0);
        set_in(2'b11, gen_instr(2), gen_instr(2));
        cyc();
        chk("t3_ignored_count", 64'(count), 64'd8);
        out_take = 2'b11;
        cyc();
        out_take = 2'b00;
        set_in(2'b00, 32'h0, 32'h0);
        chk("t3_after_take_count", 64'(count), 64'd6);
        chk("t3_after_take_ready", 64'(in_ready), 64'd1);
        budget = 0;
        while (mq.size() > 0 && budget < 20) begin
            out_take = m_valid();
            cyc();
            budget++;
        end
        out_take = 2'b00;
        chk("t3_drained", 64'(mq.size() == 0), 64'd1);

        // 4: stream 20 instructions with alternating take patterns
        next_pc = 32'h100;
        k = 0;
        budget = 0;
        while (k < 20 && budget < 300) begin
            if (next_pc < 32'h100 + 32'd80) begin
                v = ($urandom_range(0, 2) == 0) ? 2'b01 : 2'b11;
                if (next_pc == 32'h100 + 32'd76) v = 2'b01;
                set_in(v, gen_instr($urandom_range(0, 17)), gen_instr($urandom_range(0, 17)));
            end else begin
                set_in(2'b00, 32'h0, 32'h0);
            end
            case (budget % 3)
                0: out_take = m_valid();
                1: out_take = m_valid() & 2'b01;
                default: out_take = 2'b00;
            endcase
            for (int i = 0; i < 2; i++) begin
                if (out_take[i]) begin
                    chk("t4_order_pc", 64'(out_pc[32*i +: 32]), 64'(32'h100 + 32'(4 * k)));
                    k++;
                end
            end
            cyc();
            budget++;
        end
        out_take = 2'b00;
        set_in(2'b00, 32'h0, 32'h0);
        chk("t4_all_issued", 64'(k), 64'd20);

        // 5: flush with enqueue and take in the same cycle
        while (mq.size() > 0 && budget < 400) begin
            out_take = m_valid();
            cyc();
            budget++;
        end
        out_take = 2'b00;
        set_in(2'b11, gen_instr(0), gen_instr(1)); cyc();
        set_in(2'b11, gen_instr(2), gen_instr(6)); cyc();
        set_in(2'b01, gen_instr(8), gen_instr(0)); cyc();
        chk("t5_count5", 64'(count), 64'd5);
        set_in(2'b11, gen_instr(0), gen_instr(0));
        flush = 1'b1;
        out_take = m_valid();
        cyc();
        flush = 1'b0;
        out_take = 2'b00;
        set_in(2'b00, 32'h0, 32'h0);
        chk("t5_flush_count", 64'(count), 64'd0);
        chk("t5_flush_valid", 64'(out_valid), 64'd0);
        chk("t5_flush_ready", 64'(in_ready), 64'd1);

        // 6: asynchronous reset between edges
        set_in(2'b11, gen_instr(0), gen_instr(1)); cyc();
        set_in(2'b01, gen_instr(2), gen_instr(0)); cyc();
        set_in(2'b00, 32'h0, 32'h0);
        chk("t6_count3", 64'(count), 64'd3);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_count", 64'(count), 64'd0);
        chk("t6_async_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // random traffic
        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(0, 2))
                0: v = 2'b00;
                1: v = 2'b01;
                default: v = 2'b11;
            endcase
            set_in(v, gen_instr($urandom_range(0, 17)), gen_instr($urandom_range(0, 17)));
            flush = ($urandom_range(0, 31) == 0);
            case ($urandom_range(0, 2))
                0: out_take = 2'b00;
                1: out_take = m_valid() & 2'b01;
                default: out_take = (m_valid() == 2'b11) ? 2'b11 : (m_valid() & 2'b01);
            endcase
            cyc();
        end
        flush = 1'b0;
        out_take = 2'b00;
        set_in(2'b00, 32'h0, 32'h0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
